// File: rtl/seg_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Segment patterns are active-low, ordered {G,F,E,D,C,B,A}.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        BLANK    = 2'd1,
        DRIVE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [15:0] bcd;
        logic [3:0]  dp;
    } disp_t;

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10-15 decode to all segments off.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit common-anode scan controller with guard blanking and tear-free updates.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] LAST_BLANK =
        PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : DRIVE;
    localparam logic [1:0] LAST_DIGIT = 2'(NUM_DIGITS - 1);

    state_t        state, state_next;
    logic [PW-1:0] presc, presc_next;
    logic [1:0]    idx_next;
    disp_t         shadow, shadow_next;
    disp_t         staging, staging_next;
    logic          pending, pending_next;

    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;
    logic       fd_next;
    logic [3:0] cur_digit;
    logic [6:0] seg_raw;
    logic       lz;
    logic       lit;
    logic       boundary;

    always_comb begin
        state_next = state;
        presc_next = presc;
        idx_next   = digit_idx;
        if (!en) begin
            state_next = DISABLED;
            presc_next = '0;
            idx_next   = '0;
        end else begin
            case (state)
                DISABLED: begin
                    state_next = SLOT_START;
                    presc_next = '0;
                    idx_next   = '0;
                end
                BLANK: begin
                    presc_next = presc + 1'b1;
                    if (presc == LAST_BLANK)
                        state_next = DRIVE;
                end
                DRIVE: begin
                    if (presc == LAST_TICK) begin
                        presc_next = '0;
                        idx_next   = digit_idx + 2'd1;
                        state_next = SLOT_START;
                    end else begin
                        presc_next = presc + 1'b1;
                    end
                end
                default: begin
                    state_next = DISABLED;
                    presc_next = '0;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Shadow only changes at a frame boundary or while the scan is idle.
    assign boundary = (state == DRIVE) && (digit_idx == LAST_DIGIT)
                   && (presc == LAST_TICK);

    always_comb begin
        shadow_next  = shadow;
        staging_next = staging;
        pending_next = pending;
        if (load) begin
            staging_next = '{bcd: bcd_in, dp: dp_in};
            pending_next = 1'b1;
        end
        if (boundary || state == DISABLED) begin
            if (load)
                shadow_next = '{bcd: bcd_in, dp: dp_in};
            else if (pending)
                shadow_next = staging;
            pending_next = 1'b0;
        end
    end

    assign cur_digit = shadow_next.bcd[{idx_next, 2'b00} +: 4];

    seg_decoder u_dec (
        .bcd (cur_digit),
        .seg (seg_raw)
    );

`ifdef SEG_SCAN_LZ_BLANK_EN
    logic z3, z2, z1;
    assign z3 = (shadow_next.bcd[15:12] == 4'd0);
    assign z2 = z3 && (shadow_next.bcd[11:8] == 4'd0);
    assign z1 = z2 && (shadow_next.bcd[7:4] == 4'd0);

    always_comb begin
        lz = 1'b0;
        case (idx_next)
            2'd3:    lz = z3;
            2'd2:    lz = z2;
            2'd1:    lz = z1;
            default: lz = 1'b0;
        endcase
    end
`else
    assign lz = 1'b0;
`endif

    // Outputs are computed from next-state values so they register alongside it.
    always_comb begin
        lit      = (state_next == DRIVE);
        an_next  = lit ? ~(4'b0001 << idx_next) : 4'hF;
        seg_next = (lit && !lz) ? seg_raw : SEG_BLANK;
        dp_next  = lit ? ~shadow_next.dp[idx_next] : 1'b1;
        fd_next  = lit && (idx_next == LAST_DIGIT)
                && (presc_next == LAST_TICK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DISABLED;
            presc      <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            staging    <= '0;
            pending    <= 1'b0;
            an         <= 4'hF;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            presc      <= presc_next;
            digit_idx  <= idx_next;
            shadow     <= shadow_next;
            staging    <= staging_next;
            pending    <= pending_next;
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_done <= fd_next;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed controller for a 4-digit common-anode 7-segment display. It shares one combinational BCD-to-segment decoder across all four digits. It cycles the active anode at a fixed rate and inserts an all-off guard interval between digits to prevent ghosting. New display values are applied only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
TICK_DIV, 100000, clock cycles per digit slot, including the guard interval; must be > BLANK_CYCLES.
BLANK_CYCLES, 1000, cycles per slot with all anodes off; 0 disables the guard interval.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
en  input  1  scan enable; 0 turns all anodes off
bcd_in  input  16  four BCD digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3
dp_in  input  4  decimal point per digit; 1 = lit
load  input  1  single-cycle pulse that stages bcd_in and dp_in
an  output  4  anode enables, active-low; an[i] selects digit i
seg  output  7  segments {G,F,E,D,C,B,A}, active-low
dp  output  1  decimal point, active-low
digit_idx  output  2  digit currently in its slot
frame_done  output  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset (async assert, sync release): an=4'hF, seg=7'h7F, dp=1, digit_idx=0, frame_done=0, state=DISABLED, prescaler=0. Shadow and staging registers clear to 0; pending clears to 0.
- States:
  - DISABLED: taken while en=0.
  - BLANK: an=4'hF for BLANK_CYCLES cycles; skipped when BLANK_CYCLES=0.
  - DRIVE: an[digit_idx]=0, all other anode bits 1, for TICK_DIV-BLANK_CYCLES cycles.
- Transitions:
  - DISABLED→BLANK (or →DRIVE if BLANK_CYCLES=0) on the cycle after en=1.
  - BLANK→DRIVE when the prescaler reaches BLANK_CYCLES-1.
  - DRIVE→BLANK (or →DRIVE) when the prescaler reaches TICK_DIV-1; digit_idx then increments, wrapping from 3 to 0.
  - Every slot lasts exactly TICK_DIV cycles; a frame lasts 4*TICK_DIV cycles.
- en=0 in any state: the next cycle goes to DISABLED with an=4'hF, seg=7'h7F, dp=1, digit_idx=0, prescaler=0. Shadow registers are retained.
- All outputs are registered. an, seg and dp change in the same cycle as the state change and have no glitch path.
- seg/dp while an is all-off: 7'h7F/1.
- Decode: 0–9 use the standard patterns (e.g. 0→7'h40, 1→7'h79, 8→7'h00). Codes 10–15 produce 7'h7F (blank). Decoding always uses the shadow registers, never bcd_in directly.
- load:
  - Captures bcd_in/dp_in into staging and sets pending.
  - A second load before the boundary overwrites staging; last value wins.
- Frame boundary (last DRIVE cycle of digit 3):
  - frame_done=1 for that cycle only.
  - If pending: shadow←staging and pending←0.
  - load in the same cycle: its value goes directly to shadow, and pending ends at 0.
- While DISABLED, load writes shadow directly and pending stays 0.

Optional Feature:
Macro: SEG_SCAN_LZ_BLANK_EN.
- Defined: digit i in {3,2,1} is blanked (seg=7'h7F, dp follows dp_in) when it and all higher shadow digits are 0. Digit 0 is never blanked. The anode timing does not change.
- Undefined: every digit displays, including leading zeros.

Decomposition:
- Shared package seg_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK=7'h7F
  - state encoding: DISABLED, BLANK, DRIVE
  - NUM_DIGITS=4
- One sub-module, seg_decoder: purely combinational 4-bit BCD to 7-bit active-low segments. Instantiated once, with its input muxed by digit_idx.

Test Plan:
- Bench parameters: TICK_DIV=8, BLANK_CYCLES=2.
- Reset and idle: hold rst_n=0, then release with en=0 → an=4'hF, seg=7'h7F, dp=1 indefinitely; frame_done never pulses.
- Basic scan: load bcd_in=16'h1234, dp_in=4'b0001, then en=1 →
  - an sequence 1111×2, 1110×6, 1111×2, 1101×6, and so on
  - seg during digit 0 = pattern for 4 with dp=0; digit 1 = 3, digit 2 = 2, digit 3 = 1 with dp=1
  - frame_done pulses every 32 cycles
- Tear-free update: mid-frame load of 16'h9876 → the current frame still shows 1234; the next frame shows 9876. A double load of 16'h1111 then 16'h2222 in one frame → the next frame shows 2222.
- Invalid codes: bcd_in=16'hFA09 → digits 3 and 2 show seg=7'h7F during their DRIVE slots; digit 1 shows 0, digit 0 shows 9.
- Disable mid-digit: deassert en during digit 2 DRIVE → the next cycle gives an=4'hF and digit_idx=0. Re-enable → the scan restarts at digit 0 with a BLANK slot. Async reset asserted mid-DRIVE → outputs return to reset values immediately.
- Leading-zero blanking: with SEG_SCAN_LZ_BLANK_EN, shadow 16'h0050 → digit 3 blank, digit 2 blank, digit 1 shows 5, digit 0 shows 0. Shadow 16'h0000 → only digit 0 is lit. Without the macro, all four digits are lit.
